// File: rtl/branch_exec_queue.sv
// branch_exec_queue: FIFO of issued branch/jump ops resolved from the head into a registered valid/ready result.
// Define BRANCH_STATS_EN to add saturating handshake/mispredict counters.
module branch_exec_queue #(
  parameter int XLEN      = 32,
  parameter int OP_WIDTH  = 6,
  parameter int DEPTH     = 4,
  parameter int TAG_WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [OP_WIDTH-1:0]  in_op,
  input  logic [XLEN-1:0]      in_opA,
  input  logic [XLEN-1:0]      in_opB,
  input  logic [XLEN-1:0]      in_imm,
  input  logic [XLEN-1:0]      in_pc,
  input  logic [XLEN-1:0]      in_pred,
  input  logic [TAG_WIDTH-1:0] in_tag,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [XLEN-1:0]      out_target,
  output logic                 out_taken,
  output logic                 out_mispredict,
  output logic [XLEN-1:0]      out_link,
`ifdef BRANCH_STATS_EN
  output logic [TAG_WIDTH-1:0] out_tag,
  output logic [31:0]          stat_resolved,
  output logic [31:0]          stat_mispred
`else
  output logic [TAG_WIDTH-1:0] out_tag
`endif
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [OP_WIDTH-1:0] OP_BEQ  = OP_WIDTH'(0);
  localparam logic [OP_WIDTH-1:0] OP_BNE  = OP_WIDTH'(1);
  localparam logic [OP_WIDTH-1:0] OP_BLT  = OP_WIDTH'(4);
  localparam logic [OP_WIDTH-1:0] OP_BGE  = OP_WIDTH'(5);
  localparam logic [OP_WIDTH-1:0] OP_BLTU = OP_WIDTH'(6);
  localparam logic [OP_WIDTH-1:0] OP_BGEU = OP_WIDTH'(7);
  localparam logic [OP_WIDTH-1:0] OP_JAL  = OP_WIDTH'(8);
  localparam logic [OP_WIDTH-1:0] OP_JALR = OP_WIDTH'(9);

  typedef struct packed {
    logic [OP_WIDTH-1:0]  op;
    logic [XLEN-1:0]      a;
    logic [XLEN-1:0]      b;
    logic [XLEN-1:0]      imm;
    logic [XLEN-1:0]      pc;
    logic [XLEN-1:0]      pred;
    logic [TAG_WIDTH-1:0] tag;
  } entry_t;

  typedef struct packed {
    logic                 valid;
    logic [XLEN-1:0]      target;
    logic                 taken;
    logic                 mis;
    logic [XLEN-1:0]      link;
    logic [TAG_WIDTH-1:0] tag;
  } out_t;

  entry_t          mem_q [DEPTH];
  entry_t          mem_d [DEPTH];
  logic [AW-1:0]   wptr_q, wptr_d, rptr_q, rptr_d;
  logic [AW:0]     cnt_q, cnt_d;
  out_t            out_q, out_d;
  entry_t          head;
  logic            push, pop, eq, lt, ltu, taken, is_jal, is_jalr;
  logic [XLEN-1:0] target, link;

  always_comb begin
    head    = mem_q[rptr_q];
    eq      = head.a == head.b;
    lt      = $signed(head.a) < $signed(head.b);
    ltu     = head.a < head.b;
    is_jal  = head.op == OP_JAL;
    is_jalr = head.op == OP_JALR;
    taken   = (head.op == OP_BEQ)  ? eq  :
              (head.op == OP_BNE)  ? ~eq :
              (head.op == OP_BLT)  ? lt  :
              (head.op == OP_BGE)  ? ~lt :
              (head.op == OP_BLTU) ? ltu :
              (head.op == OP_BGEU) ? ~ltu :
              (is_jal | is_jalr);
    target  = is_jalr ? ((head.a + head.imm) & ~XLEN'(1)) :
              taken   ? head.pc + head.imm : head.pc + XLEN'(4);
    link    = (is_jal | is_jalr) ? head.pc + XLEN'(4) : '0;
  end

  // A full queue refuses input even when the head leaves this cycle.
  assign in_ready = cnt_q != (AW+1)'(DEPTH);
  assign push     = in_valid & in_ready;
  assign pop      = (cnt_q != '0) & (~out_q.valid | out_ready);

  always_comb begin
    mem_d  = mem_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    out_d  = out_q;
    if (flush) begin
      wptr_d = '0;
      rptr_d = '0;
      cnt_d  = '0;
      out_d  = '0;
    end else begin
      if (push) begin
        mem_d[wptr_q] = '{in_op, in_opA, in_opB, in_imm, in_pc, in_pred, in_tag};
        wptr_d        = wptr_q + AW'(1);
      end
      if (pop) begin
        rptr_d = rptr_q + AW'(1);
        out_d  = '{1'b1, target, taken, target != head.pred, link, head.tag};
      end else if (out_ready) begin
        out_d.valid = 1'b0;
      end
      cnt_d = cnt_q + (AW+1)'(push) - (AW+1)'(pop);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_q  <= '{default: '0};
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
      out_q  <= '0;
    end else begin
      mem_q  <= mem_d;
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
      out_q  <= out_d;
    end
  end

  assign out_valid      = out_q.valid;
  assign out_target     = out_q.target;
  assign out_taken      = out_q.taken;
  assign out_mispredict = out_q.mis;
  assign out_link       = out_q.link;
  assign out_tag        = out_q.tag;

`ifdef BRANCH_STATS_EN
  logic        hs;
  logic [31:0] res_q, res_d, mis_q, mis_d;

  // Counters survive flush; only reset clears them.
  always_comb begin
    hs    = out_q.valid & out_ready;
    res_d = (hs & ~&res_q) ? res_q + 32'd1 : res_q;
    mis_d = (hs & out_q.mis & ~&mis_q) ? mis_q + 32'd1 : mis_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      res_q <= '0;
      mis_q <= '0;
    end else begin
      res_q <= res_d;
      mis_q <= mis_d;
    end
  end

  assign stat_resolved = res_q;
  assign stat_mispred  = mis_q;
`endif
endmodule
